bin_to_display_codes: RTL and testbench
=======================================

# bin_to_display_codes

Sequential binary-to-decimal formatter that produces the packed 30-bit digit-code word consumed by the six-digit seven-segment display driver. It accepts an unsigned 20-bit value on a start/busy/done handshake and runs an iterative double-dabble conversion. It then applies leading-zero blanking and overflow indication and holds six 5-bit display codes stable until the next conversion completes. It sits between datapath logic (counters, measurement results) and the display driver.

## Interface
- BLANK_CODE, 5'd16, display code that renders an all-off digit
- DASH_CODE, 5'd17, display code that renders a single middle segment ("-")
- LZ_BLANK, 1, 1 = blank leading zeros; 0 = show all six digits
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a conversion; sampled only in IDLE
- value  in  20  unsigned binary value; captured on the accepted start
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when data_out/overflow have been updated
- overflow  out  1  high when the last converted value exceeded 999999
- data_out  out  30  six packed codes; [4:0] = least significant digit (HEX0), [29:25] = most significant (HEX5)

## Operation
- Reset values: state IDLE, busy=0, done=0, overflow=0, data_out = six copies of BLANK_CODE.
- States: IDLE -> CONVERT -> FORMAT -> IDLE.
- IDLE: on start=1, capture value into a 20-bit shift register, clear the 24-bit BCD register and the 5-bit iteration counter, and capture ovf_pend = (value > 999999). Go to CONVERT.
- CONVERT: one double-dabble iteration per cycle, 20 iterations total. Each iteration adds 3 to every BCD nibble >= 5, then shifts {bcd, bin} left by 1. After iteration 20, go to FORMAT.
- FORMAT: register the outputs, assert done for one cycle, clear busy, and return to IDLE.
  - If ovf_pend: data_out = six DASH_CODE, overflow=1.
  - Else: digit i = {1'b0, bcd[4i+3:4i]}, overflow=0.
  - With LZ_BLANK=1, every digit above the most significant nonzero digit becomes BLANK_CODE. Digit 0 is never blanked.
- BCD contents are undefined for overflowed values and are discarded; the 24-bit BCD register does not widen.
- start while busy=1 is ignored; the value is not queued.
- data_out and overflow change only in the FORMAT cycle or on reset; they are otherwise held.
- Reset mid-conversion aborts immediately: no done pulse, and outputs return to their reset values.

## Timing
- Start accepted at edge N; busy=1 from after edge N through edge N+21.
- Iterations occur on edges N+1..N+20. FORMAT updates outputs at edge N+21.
- done=1 for exactly one cycle after edge N+21, coincident with busy falling.
- Latency is fixed at 21 cycles from accept to outputs valid, independent of value.
- Back-to-back operation: start=1 during the done cycle is accepted because the state is IDLE. Minimum issue interval is 22 cycles.
- done and busy are never both high.

## Test plan
- Reset, then value=0 with start: after 21 cycles done pulses; data_out = {B,B,B,B,B,0} (B=16), overflow=0.
- value=123456: data_out digits HEX5..HEX0 = 1,2,3,4,5,6 (data_out=30'h... packed codes 1..6); busy high exactly 21 cycles.
- value=1000, LZ_BLANK=1: HEX5,HEX4=16, HEX3=1, HEX2..HEX0=0. Repeat with LZ_BLANK=0: HEX5..HEX0 = 0,0,1,0,0,0.
- value=999999: all digits 9, overflow=0. Then value=1000000: all digits 17, overflow=1. Then value=20'hFFFFF: same dash result.
- Assert start again during the done cycle with value=42: accepted; next done exactly 22 cycles after the previous one. Pulse start mid-conversion with value=7: ignored, and the result reflects the first value.
- Assert rst at iteration 10: no done pulse; data_out = all 16, busy=0, overflow=0; a fresh start then converts correctly.

Source files
------------

// File: rtl/bin_to_display_codes.sv
// bin_to_display_codes
//
// Sequential binary-to-decimal formatter for a six-digit seven-segment
// display driver. A 20-bit unsigned value is converted with an iterative
// double-dabble (one iteration per clock, 20 iterations). The result then
// gets leading-zero blanking and overflow indication, and is presented as
// six packed 5-bit display codes.
//
// Handshake: start is sampled only while the FSM is IDLE; a start that is
// accepted captures value on that same edge and raises busy. busy stays
// high for exactly 21 cycles. On the edge that clears busy, done rises for
// exactly one cycle, and data_out/overflow hold the new result from that
// edge onward. A start seen while busy is dropped, not queued. done and
// busy are never high together.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   start      conversion request (IDLE only)
//   value      20-bit unsigned input, captured on accepted start
//   busy       conversion in progress
//   done       one-cycle pulse when data_out/overflow update
//   overflow   last converted value exceeded 999999
//   data_out   six 5-bit codes, [4:0] = HEX0 (LSD), [29:25] = HEX5 (MSD)
//   state_dbg  current FSM state (IDLE=0, CONVERT=1, FORMAT=2)
module bin_to_display_codes #(
  parameter logic [4:0] BLANK_CODE = 5'd16,
  parameter logic [4:0] DASH_CODE  = 5'd17,
  parameter logic       LZ_BLANK   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] value,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [29:0] data_out,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] FORMAT  = 2'd2;

  localparam logic [4:0] LAST_ITER = 5'd19;

  logic [1:0]  state;
  logic [19:0] bin_sr;
  logic [23:0] bcd;
  logic [4:0]  iter_cnt;
  logic        ovf_pend;

  logic [23:0] bcd_adj;
  logic [23:0] bcd_next;
  logic [19:0] bin_next;
  logic [29:0] fmt_codes;

  assign state_dbg = state;

  // One double-dabble step: add 3 to every nibble >= 5, then shift the
  // concatenation {bcd, bin_sr} left by one. For overflowed inputs the
  // 4-bit add may wrap; that BCD content is discarded in FORMAT anyway.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcd_next = {bcd_adj[22:0], bin_sr[19]};
    bin_next = {bin_sr[18:0], 1'b0};
  end

  // Digit formatting. Walking from the most significant digit down, a
  // digit is blanked until the first nonzero digit is found. Digit 0 always
  // counts as "seen" so a value of zero still shows a single 0.
  always_comb begin
    logic seen_nz;
    logic [3:0] nib;
    fmt_codes = '0;
    seen_nz   = 1'b0;
    nib       = 4'd0;
    for (int i = 5; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if ((nib != 4'd0) || (i == 0)) begin
        seen_nz = 1'b1;
      end
      if (LZ_BLANK && !seen_nz) begin
        fmt_codes[5*i +: 5] = BLANK_CODE;
      end else begin
        fmt_codes[5*i +: 5] = {1'b0, nib};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      data_out <= {6{BLANK_CODE}};
      bin_sr   <= '0;
      bcd      <= '0;
      iter_cnt <= '0;
      ovf_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr   <= value;
            bcd      <= '0;
            iter_cnt <= '0;
            ovf_pend <= (value > 20'd999999);
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          bcd      <= bcd_next;
          bin_sr   <= bin_next;
          iter_cnt <= iter_cnt + 5'd1;
          if (iter_cnt == LAST_ITER) begin
            state <= FORMAT;
          end
        end
        FORMAT: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (ovf_pend) begin
            data_out <= {6{DASH_CODE}};
            overflow <= 1'b1;
          end else begin
            data_out <= fmt_codes;
            overflow <= 1'b0;
          end
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_display_codes.sv
// Testbench for bin_to_display_codes. Two instances share all inputs:
// one with leading-zero blanking, one without. Expected results are
// pushed into per-instance queues when a conversion is issued; a monitor
// pops and compares whenever done pulses.
module tb_bin_to_display_codes;

  localparam logic [4:0] B = 5'd16;
  localparam logic [4:0] D = 5'd17;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] value;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        busy_a, done_a, ovf_a;
  logic [29:0] data_a;
  logic [1:0]  st_a;
  logic        busy_b, done_b, ovf_b;
  logic [29:0] data_b;
  logic [1:0]  st_b;

  bin_to_display_codes #(.BLANK_CODE(5'd16), .DASH_CODE(5'd17), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .data_out(data_a), .state_dbg(st_a)
  );

  bin_to_display_codes #(.BLANK_CODE(5'd16), .DASH_CODE(5'd17), .LZ_BLANK(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .data_out(data_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [30:0] exp_lz_q[$];
  logic [30:0] exp_nz_q[$];
  int checks = 0;
  int passes = 0;
  bit both_high = 1'b0;
  int accept_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [29:0] pk(input logic [4:0] d5, input logic [4:0] d4,
                                     input logic [4:0] d3, input logic [4:0] d2,
                                     input logic [4:0] d1, input logic [4:0] d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  // Monitor: compare {overflow, data_out} against the queue on every done.
  always @(negedge clk) begin
    logic [30:0] e;
    if ((busy_a && done_a) || (busy_b && done_b)) both_high = 1'b1;
    if (done_a) begin
      if (exp_lz_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done_lz: got done with data %0h, expected no done", data_a);
      end else begin
        e = exp_lz_q.pop_front();
        check("result_lz", {1'b0, ovf_a, data_a}, {1'b0, e});
      end
    end
    if (done_b) begin
      if (exp_nz_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done_nz: got done with data %0h, expected no done", data_b);
      end else begin
        e = exp_nz_q.pop_front();
        check("result_nz", {1'b0, ovf_b, data_b}, {1'b0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_conv(input logic [19:0] v);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic issue(input logic [19:0] v, input logic [29:0] e_lz,
                       input logic [29:0] e_nz, input logic ovf);
    exp_lz_q.push_back({ovf, e_lz});
    exp_nz_q.push_back({ovf, e_nz});
    start_conv(v);
  endtask

  // Bounded wait for done on the blanking instance; returns at the
  // negedge inside the done cycle.
  task automatic wait_done(output int done_cyc, output int busy_cycles, output bit ok);
    busy_cycles = 0;
    ok = 1'b0;
    done_cyc = -1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (busy_a) busy_cycles++;
      if (done_a) begin
        ok = 1'b1;
        done_cyc = cyc;
      end
    end
    check("done_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic run_vec(input logic [19:0] v, input logic [29:0] e_lz,
                         input logic [29:0] e_nz, input logic ovf, output int dc);
    int bc;
    bit ok;
    issue(v, e_lz, e_nz, ovf);
    wait_done(dc, bc, ok);
    if (ok) begin
      check("latency", dc - accept_cyc, 32'd21);
      check("busy_cycles", bc, 32'd21);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int dc, prev_dc, bc, dones;
    bit ok;
    rst = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_data_lz", data_a, {6{B}});
    check("rst_data_nz", data_b, {6{B}});
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_state", st_a, 0);

    run_vec(20'd0,      pk(B, B, B, B, B, 0), pk(0, 0, 0, 0, 0, 0), 1'b0, dc);
    repeat (2) @(negedge clk);
    run_vec(20'd123456, pk(1, 2, 3, 4, 5, 6), pk(1, 2, 3, 4, 5, 6), 1'b0, dc);
    run_vec(20'd1000,   pk(B, B, 1, 0, 0, 0), pk(0, 0, 1, 0, 0, 0), 1'b0, dc);
    run_vec(20'd999999, pk(9, 9, 9, 9, 9, 9), pk(9, 9, 9, 9, 9, 9), 1'b0, dc);
    run_vec(20'd1000000, pk(D, D, D, D, D, D), pk(D, D, D, D, D, D), 1'b1, dc);
    run_vec(20'hFFFFF,  pk(D, D, D, D, D, D), pk(D, D, D, D, D, D), 1'b1, dc);
    repeat (3) @(negedge clk);
    run_vec(20'd305,    pk(B, B, B, 3, 0, 5), pk(0, 0, 0, 3, 0, 5), 1'b0, dc);

    // Back-to-back: start asserted during the done cycle, then a start
    // pulse mid-conversion that must be ignored.
    prev_dc = dc;
    issue(20'd42, pk(B, B, B, B, 4, 2), pk(0, 0, 0, 0, 4, 2), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    value = 20'd7;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(dc, bc, ok);
    if (ok) begin
      check("b2b_interval", dc - prev_dc, 32'd22);
      check("b2b_latency", dc - accept_cyc, 32'd21);
    end
    repeat (6) @(negedge clk);
    check("hold_lz", data_a, pk(B, B, B, B, 4, 2));
    check("hold_busy", busy_a, 0);

    // Reset in the middle of a conversion.
    start_conv(20'd100005);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_data_lz", data_a, {6{B}});
    check("abort_data_nz", data_b, {6{B}});
    check("abort_busy", busy_a, 0);
    check("abort_ovf", ovf_a, 0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_a || done_b) dones++;
    end
    check("abort_no_done", dones, 0);

    run_vec(20'd100005, pk(1, 0, 0, 0, 0, 5), pk(1, 0, 0, 0, 0, 5), 1'b0, dc);
    repeat (2) @(negedge clk);
    run_vec(20'd42,     pk(B, B, B, B, 4, 2), pk(0, 0, 0, 0, 4, 2), 1'b0, dc);
    repeat (3) @(negedge clk);

    // ---------------- final report ----------------
    check("busy_done_exclusive", {31'd0, both_high}, 0);
    check("queue_lz_drained", exp_lz_q.size(), 0);
    check("queue_nz_drained", exp_nz_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
